// File: rtl/drum_pkg.sv
// drum_pkg: shared constants, index-width helper and state types for the drum step sequencer
//   DEF_TRACKS / DEF_STEPS - default track and step counts
//   MIN_PERIOD             - shortest step period in clocks
//   idx_w()                - index width for a count of items
//   seq_state_t            - sequencer play state
//   gate_state_t           - per-track gate state
package drum_pkg;

    localparam int DEF_TRACKS = 4;
    localparam int DEF_STEPS  = 16;
    localparam int MIN_PERIOD = 4;

    typedef enum logic { IDLE, PLAY } seq_state_t;

    typedef enum logic [1:0] { G_OFF, G_ON, G_RETRIG } gate_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drum_gate_timer.sv
// drum_gate_timer: per-track timed enable gate with a one-cycle gap on retrigger
//   clk, rst  - clock, synchronous active-high reset
//   trig      - start (or restart) the gate this cycle
//   gate_len  - clocks the enable is held; 0 behaves as 1
//   kill      - force the gate off immediately (wins over trig)
//   en        - player enable
module drum_gate_timer
    import drum_pkg::*;
#(
    parameter int GATE_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              kill,
    output logic              en
);

    gate_state_t       state_q, state_d;
    logic [GATE_W-1:0] cnt_q, cnt_d, len_eff;

    // A trigger while the gate is open passes through G_RETRIG so the player
    // sees one low cycle and restarts; the length is captured at trigger time.
    always_comb begin
        len_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
            state_d = G_OFF;
            cnt_d   = '0;
        end else if (trig) begin
            state_d = (state_q == G_ON) ? G_RETRIG : G_ON;
            cnt_d   = len_eff;
        end else if (state_q == G_RETRIG) begin
            state_d = G_ON;
        end else if (state_q == G_ON) begin
            state_d = (cnt_q == GATE_W'(1)) ? G_OFF : G_ON;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= G_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en = (state_q == G_ON);

endmodule

// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer: track-by-step trigger pattern driving timed sample-player enables
//   clk, rst     - clock, synchronous active-high reset (also clears the pattern)
//   run          - 1 = play, 0 = stop and rewind to step 0
//   step_period  - clocks per step; values below MIN_PERIOD behave as MIN_PERIOD
//   swing_amt    - swing offset, present only with DRUM_SEQ_SWING_EN defined
//   gate_len     - clocks each enable is held per trigger; 0 behaves as 1
//   wr_en, wr_track, wr_step, wr_val - pattern bit write port
//   sample_en    - per-track player enable
//   step_idx     - current step
//   step_tick    - one-cycle pulse on each step boundary
// Optional feature macro: DRUM_SEQ_SWING_EN (even steps longer, odd steps shorter).
module drum_step_sequencer
    import drum_pkg::*;
#(
    parameter int NUM_TRACKS = DEF_TRACKS,
    parameter int NUM_STEPS  = DEF_STEPS,
    parameter int PERIOD_W   = 24,
    parameter int GATE_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [PERIOD_W-1:0]          step_period,
`ifdef DRUM_SEQ_SWING_EN
    input  logic [PERIOD_W-1:0]          swing_amt,
`endif
    input  logic [GATE_W-1:0]            gate_len,
    input  logic                         wr_en,
    input  logic [idx_w(NUM_TRACKS)-1:0] wr_track,
    input  logic [idx_w(NUM_STEPS)-1:0]  wr_step,
    input  logic                         wr_val,
    output logic [NUM_TRACKS-1:0]        sample_en,
    output logic [idx_w(NUM_STEPS)-1:0]  step_idx,
    output logic                         step_tick
);

    localparam int SW = idx_w(NUM_STEPS);
    localparam int CW = PERIOD_W + 1;

    seq_state_t                           state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d, p_eff, dur;
    logic [SW-1:0]                        step_q, step_d;
    logic                                 tick_q, tick_d;
    logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pat_q;

    // One extra counter bit so a swung even step (period + s) cannot overflow.
    always_comb begin
        p_eff = (step_period < PERIOD_W'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : {1'b0, step_period};
    end

`ifdef DRUM_SEQ_SWING_EN
    logic [CW-1:0] half, swing;
    logic          load_odd;

    // The step being loaded is step 0 from IDLE, otherwise step_q + 1.
    always_comb begin
        load_odd = (state_q == PLAY) & ~step_q[0];
        half     = p_eff >> 1;
        swing    = ({1'b0, swing_amt} > half) ? half : {1'b0, swing_amt};
        dur      = load_odd ? p_eff - swing : p_eff + swing;
    end
`else
    always_comb begin
        dur = p_eff;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        tick_d  = 1'b0;
        if (state_q == IDLE) begin
            if (run) begin
                state_d = PLAY;
                step_d  = '0;
                tick_d  = 1'b1;
                cnt_d   = dur - 1'b1;
            end
        end else if (!run) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (cnt_q == '0) begin
            step_d = step_q + 1'b1;
            tick_d = 1'b1;
            cnt_d  = dur - 1'b1;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            tick_q  <= 1'b0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            if (wr_en) pat_q[wr_track][wr_step] <= wr_val;
        end
    end

    // Triggers are taken in the tick cycle from the registered pattern, so a
    // write landing on that same cycle only affects the next pass.
    for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_trk
        drum_gate_timer #(
            .GATE_W(GATE_W)
        ) u_gate (
            .clk      (clk),
            .rst      (rst),
            .trig     (tick_q & pat_q[i][step_q]),
            .gate_len (gate_len),
            .kill     (~run),
            .en       (sample_en[i])
        );
    end

    assign step_idx  = step_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb_drum_step_sequencer: directed and random stimulus against a timeline reference model
module tb_drum_step_sequencer;

    localparam int NT = 4;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          rst, run, wr_en, wr_val, step_tick;
    logic [23:0]   step_period;
`ifdef DRUM_SEQ_SWING_EN
    logic [23:0]   swing_amt;
`endif
    logic [11:0]   gate_len;
    logic [1:0]    wr_track;
    logic [3:0]    wr_step, step_idx;
    logic [NT-1:0] sample_en;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle numbers for step boundaries and the
    // enable window [en_from, en_to] of each track.
    int now = 0;
    int tick_cyc = -100;
    int next_tick = 0;
    int step = 0;
    bit playing = 1'b0;
    bit pat [NT][NS];
    int en_from [NT];
    int en_to [NT];

    always #5 clk = ~clk;

    drum_step_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_period (step_period),
`ifdef DRUM_SEQ_SWING_EN
        .swing_amt   (swing_amt),
`endif
        .gate_len    (gate_len),
        .wr_en       (wr_en),
        .wr_track    (wr_track),
        .wr_step     (wr_step),
        .wr_val      (wr_val),
        .sample_en   (sample_en),
        .step_idx    (step_idx),
        .step_tick   (step_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dur(input int st);
        int p, s;
        p = (step_period < 24'd4) ? 4 : int'(step_period);
        s = 0;
`ifdef DRUM_SEQ_SWING_EN
        s = (int'(swing_amt) > p / 2) ? p / 2 : int'(swing_amt);
`endif
        return (st % 2 == 1) ? p - s : p + s;
    endfunction

    task automatic clk_step();
        bit            fire [NT];
        int            len;
        logic [NT-1:0] e;
        @(posedge clk);
        now++;
        len = (gate_len == 12'd0) ? 1 : int'(gate_len);
        for (int t = 0; t < NT; t++) fire[t] = run && playing && tick_cyc == now - 1 && pat[t][step];
        if (rst) begin
            playing  = 1'b0;
            step     = 0;
            tick_cyc = -100;
            for (int t = 0; t < NT; t++) begin
                en_from[t] = 0;
                en_to[t]   = -1;
                for (int s = 0; s < NS; s++) pat[t][s] = 1'b0;
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (fire[t]) begin
                    if (en_from[t] <= now - 1 && now - 1 <= en_to[t]) begin
                        en_from[t] = now + 1;
                        en_to[t]   = now + len;
                    end else begin
                        en_from[t] = now;
                        en_to[t]   = now + len - 1;
                    end
                end
            end
            if (playing && !run) begin
                playing = 1'b0;
                step    = 0;
                for (int t = 0; t < NT; t++) begin
                    en_from[t] = 0;
                    en_to[t]   = -1;
                end
            end else if (!playing && run) begin
                playing   = 1'b1;
                step      = 0;
                tick_cyc  = now;
                next_tick = now + dur(0);
            end else if (playing && now == next_tick) begin
                step      = (step + 1) % NS;
                tick_cyc  = now;
                next_tick = now + dur(step);
            end
            if (wr_en) pat[wr_track][wr_step] = wr_val;
        end
        #1;
        for (int t = 0; t < NT; t++) e[t] = (en_from[t] <= now && now <= en_to[t]);
        chk("step_tick", 32'(step_tick), 32'(tick_cyc == now));
        chk("step_idx", 32'(step_idx), 32'(step));
        chk("sample_en", 32'(sample_en), 32'(e));
    endtask

    task automatic wr(input int t, input int s, input bit v);
        wr_en    = 1'b1;
        wr_track = 2'(t);
        wr_step  = 4'(s);
        wr_val   = v;
        clk_step();
        wr_en    = 1'b0;
    endtask

    task automatic wait_tick(input int s);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            clk_step();
            hit = (step_tick === 1'b1) && (step_idx === 4'(s));
        end
        chk("wait_tick", 32'(hit), 32'd1);
    endtask

    initial begin
        int last, cnt, ntk;
        rst         = 1'b1;
        run         = 1'b0;
        step_period = 24'd10;
        gate_len    = 12'd5;
        wr_en       = 1'b0;
        wr_track    = 2'd0;
        wr_step     = 4'd0;
        wr_val      = 1'b0;
`ifdef DRUM_SEQ_SWING_EN
        swing_amt   = 24'd0;
`endif
        repeat (3) clk_step();
        chk("rst_en", 32'(sample_en), 32'd0);
        chk("rst_idx", 32'(step_idx), 32'd0);
        chk("rst_tick", 32'(step_tick), 32'd0);
        rst = 1'b0;
        repeat (2) clk_step();

        // Empty pattern: tick every 10 clocks, index walks and wraps.
        run  = 1'b1;
        last = -1;
        repeat (170) begin
            clk_step();
            if (step_tick === 1'b1) begin
                if (last >= 0) chk("tick_gap", 32'(now - last), 32'd10);
                last = now;
            end
        end
        run = 1'b0;
        repeat (2) clk_step();

        // Single trigger on track 0 step 0, three passes.
        wr(0, 0, 1'b1);
        gate_len = 12'd5;
        run      = 1'b1;
        cnt      = 0;
        repeat (330) begin
            clk_step();
            cnt += int'(sample_en[0]);
        end
        chk("gate5_cycles", 32'(cnt), 32'd15);
        run = 1'b0;
        clk_step();

        // Retrigger on track 1 steps 0 and 1 with a gate longer than a step.
        wr(1, 0, 1'b1);
        wr(1, 1, 1'b1);
        gate_len = 12'd20;
        run      = 1'b1;
        cnt      = 0;
        for (int i = 1; i <= 40; i++) begin
            clk_step();
            cnt += int'(sample_en[1]);
            if (i == 12) chk("retrig_gap", 32'(sample_en[1]), 32'd0);
            if (i == 13) chk("retrig_resume", 32'(sample_en[1]), 32'd1);
        end
        chk("retrig_high", 32'(cnt), 32'd30);

        // Stop during step 5 with a gate open, then restart.
        wr(2, 5, 1'b1);
        wait_tick(5);
        repeat (3) clk_step();
        chk("pre_stop_en", 32'(sample_en[2]), 32'd1);
        run = 1'b0;
        clk_step();
        chk("stop_en", 32'(sample_en), 32'd0);
        chk("stop_idx", 32'(step_idx), 32'd0);
        repeat (4) clk_step();
        run = 1'b1;
        clk_step();
        chk("restart_tick", 32'(step_tick), 32'd1);
        chk("restart_idx", 32'(step_idx), 32'd0);

        // Write to the firing step on its boundary cycle.
        wait_tick(3);
        wr(3, 3, 1'b1);
        chk("collision_old", 32'(sample_en[3]), 32'd0);
        wait_tick(3);
        clk_step();
        chk("collision_new", 32'(sample_en[3]), 32'd1);

        // Reset in the middle of a gate clears outputs and the pattern.
        rst = 1'b1;
        clk_step();
        chk("rst2_en", 32'(sample_en), 32'd0);
        chk("rst2_idx", 32'(step_idx), 32'd0);
        chk("rst2_tick", 32'(step_tick), 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (200) begin
            clk_step();
            cnt += int'(sample_en != 4'd0);
        end
        chk("cleared_pattern", 32'(cnt), 32'd0);

`ifdef DRUM_SEQ_SWING_EN
        // Swing clamped to half the period: 30/10 alternation.
        run = 1'b0;
        clk_step();
        step_period = 24'd20;
        swing_amt   = 24'd15;
        run         = 1'b1;
        last        = -1;
        ntk         = 0;
        repeat (130) begin
            clk_step();
            if (step_tick === 1'b1) begin
                if (last >= 0) chk("swing_gap", 32'(now - last), (ntk % 2 == 1) ? 32'd30 : 32'd10);
                last = now;
                ntk++;
            end
        end
        swing_amt = 24'd0;
`else
        ntk = 0;
`endif

        // Random writes, period/gate changes, run toggles and rare resets.
        step_period = 24'd8;
        gate_len    = 12'd6;
        run         = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_track = 2'($urandom_range(0, 3));
            wr_step  = 4'($urandom_range(0, 15));
            wr_val   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) step_period = 24'($urandom_range(0, 14));
            if ($urandom_range(0, 49) == 0) gate_len = 12'($urandom_range(0, 25));
            if ($urandom_range(0, 199) == 0) run = ~run;
`ifdef DRUM_SEQ_SWING_EN
            if ($urandom_range(0, 49) == 0) swing_amt = 24'($urandom_range(0, 10));
`endif
            rst = ($urandom_range(0, 999) == 0);
            clk_step();
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        clk_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
